// File: rtl/matrix_transpose_stream_if.sv
// Row-stream bus between a producer/consumer pair and matrix_transpose_stream.
// The master modport is the environment side; the slave modport is the block side.
interface matrix_transpose_stream_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 8
);
    logic                       ctrl;
    logic                       in_val;
    logic                       in_rdy;
    logic [N*DATA_WIDTH-1:0]    in_row;
    logic                       out_val;
    logic                       out_rdy;
    logic [N*DATA_WIDTH-1:0]    out_row;
    logic                       out_last;

    modport master (
        output ctrl, in_val, in_row, out_rdy,
        input  in_rdy, out_val, out_row, out_last
    );

    modport slave (
        input  ctrl, in_val, in_row, out_rdy,
        output in_rdy, out_val, out_row, out_last
    );
endinterface

// File: rtl/matrix_transpose_stream.sv
// Streaming N x N matrix transpose / pass-through with ping-pong row banks.
// Rows are written into one bank while the other bank is read out column- or row-wise.
module matrix_transpose_stream #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    matrix_transpose_stream_if.slave  bus
);
    localparam int unsigned CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [DATA_WIDTH-1:0] bank [2][N][N];
    logic [1:0]            mode;
    logic [1:0]            full;
    logic                  wbank;
    logic                  rbank;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;

    logic                  in_fire;
    logic                  out_fire;
    logic                  wr_last;
    logic                  rd_last;

    // Handshakes depend only on registered flags and rst, never on out_rdy.
    always_comb begin
        wr_last      = (wr_cnt == LAST);
        rd_last      = (rd_cnt == LAST);
        bus.in_rdy   = !rst && !full[wbank];
        bus.out_val  = !rst && full[rbank];
        bus.out_last = bus.out_val && rd_last;
        in_fire      = bus.in_val && bus.in_rdy;
        out_fire     = bus.out_val && bus.out_rdy;
    end

    // Bank bookkeeping; fill and drain always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 2'b00;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire) begin
                if (wr_last) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    wr_cnt      <= '0;
                end else begin
                    wr_cnt      <= wr_cnt + CW'(1);
                end
            end
            if (out_fire) begin
                if (rd_last) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                    rd_cnt      <= '0;
                end else begin
                    rd_cnt      <= rd_cnt + CW'(1);
                end
            end
        end
    end

    // Element storage and per-matrix mode; intentionally not reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < int'(N); c++) begin
                bank[wbank][wr_cnt][c] <= bus.in_row[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (wr_cnt == '0) begin
                mode[wbank] <= bus.ctrl;
            end
        end
    end

    // Column read when transposing, row read when passing through.
    always_comb begin
        bus.out_row = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (mode[rbank]) begin
                bus.out_row[k*DATA_WIDTH +: DATA_WIDTH] = bank[rbank][k][rd_cnt];
            end else begin
                bus.out_row[k*DATA_WIDTH +: DATA_WIDTH] = bank[rbank][rd_cnt][k];
            end
        end
    end
endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Self-checking bench for matrix_transpose_stream (N=4, 16-bit elements).
// A queue-of-matrices reference model checks every cycle; tables and sequences cover corners.
module tb_matrix_transpose_stream;
    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef struct {
        logic              ctrl0;
        logic              tog;
        logic [N-1:0][63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    matrix_transpose_stream_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    matrix_transpose_stream #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: complete matrices awaiting output, plus the one being filled.
    mat_t mq[$];
    bit   modeq[$];
    mat_t part;
    bit   part_mode;
    int   part_rows = 0;
    int   rd = 0;

    logic        obs_in_rdy;
    logic        obs_out_val;
    logic        obs_out_last;
    logic [63:0] obs_out_row;

    mat_t ref_in;
    vec_t vecs [4];

    function automatic logic [63:0] model_row(input mat_t m, input bit md, input int k);
        logic [N-1:0][DW-1:0] r;
        for (int c = 0; c < int'(N); c++) begin
            r[c] = md ? m[c][k] : m[k][c];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cyc(input logic r, input logic v, input logic [63:0] row,
                       input logic c, input logic ordy);
        logic e_in_rdy;
        logic e_out_val;
        logic e_out_last;
        bit   in_f;
        bit   out_f;
        rst         = r;
        bus.in_val  = v;
        bus.in_row  = row;
        bus.ctrl    = c;
        bus.out_rdy = ordy;
        @(negedge clk);
        e_in_rdy   = !r && (mq.size() < 2);
        e_out_val  = !r && (mq.size() > 0);
        e_out_last = e_out_val && (rd == int'(N) - 1);
        obs_in_rdy   = bus.in_rdy;
        obs_out_val  = bus.out_val;
        obs_out_last = bus.out_last;
        obs_out_row  = bus.out_row;
        chk("in_rdy", 64'(obs_in_rdy), 64'(e_in_rdy));
        chk("out_val", 64'(obs_out_val), 64'(e_out_val));
        chk("out_last", 64'(obs_out_last), 64'(e_out_last));
        if (e_out_val) chk("out_row", obs_out_row, model_row(mq[0], modeq[0], rd));
        in_f  = v && e_in_rdy;
        out_f = e_out_val && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            modeq.delete();
            part_rows = 0;
            rd = 0;
        end else begin
            if (out_f) begin
                rd++;
                if (rd == int'(N)) begin
                    rd = 0;
                    void'(mq.pop_front());
                    void'(modeq.pop_front());
                end
            end
            if (in_f) begin
                part[part_rows] = row;
                if (part_rows == 0) part_mode = c;
                part_rows++;
                if (part_rows == int'(N)) begin
                    mq.push_back(part);
                    modeq.push_back(part_mode);
                    part_rows = 0;
                end
            end
        end
    endtask

    initial begin
        int   acc;
        int   drops;
        int   hi;
        logic cb;

        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++)
                ref_in[r][c] = DW'(16 * r + c);

        vecs[0] = '{ctrl0: 1'b1, tog: 1'b0, exp: {64'h0033_0023_0013_0003, 64'h0032_0022_0012_0002,
                                                 64'h0031_0021_0011_0001, 64'h0030_0020_0010_0000}};
        vecs[1] = '{ctrl0: 1'b0, tog: 1'b0, exp: {64'h0033_0032_0031_0030, 64'h0023_0022_0021_0020,
                                                 64'h0013_0012_0011_0010, 64'h0003_0002_0001_0000}};
        vecs[2] = '{ctrl0: 1'b1, tog: 1'b1, exp: vecs[0].exp};
        vecs[3] = '{ctrl0: 1'b0, tog: 1'b1, exp: vecs[1].exp};

        // Reset state
        cyc(1'b1, 1'b1, 64'h0, 1'b0, 1'b1);
        chk("rst in_rdy", 64'(obs_in_rdy), 64'd0);
        chk("rst out_val", 64'(obs_out_val), 64'd0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        // Table: transpose, pass-through, and ctrl ignored after row 0
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < int'(N); r++) begin
                cb = (r == 0) ? vecs[i].ctrl0 : (vecs[i].tog ? (vecs[i].ctrl0 ^ (r % 2 == 1)) : vecs[i].ctrl0);
                cyc(1'b0, 1'b1, ref_in[r], cb, 1'b0);
            end
            for (int k = 0; k < int'(N); k++) begin
                cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
                if (k == 0) chk($sformatf("vec%0d latency", i), 64'(obs_out_val), 64'd1);
                chk($sformatf("vec%0d row%0d", i, k), obs_out_row, vecs[i].exp[k]);
                chk($sformatf("vec%0d last%0d", i, k), 64'(obs_out_last), 64'(k == int'(N) - 1));
            end
            cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
            chk($sformatf("vec%0d drained", i), 64'(obs_out_val), 64'd0);
        end

        // Backpressure: two matrices buffered, then in_rdy drops
        acc = 0;
        for (int cy = 1; cy <= 10; cy++) begin
            cyc(1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom), 1'b0);
            if (obs_in_rdy) acc++;
            if (cy >= 9) chk($sformatf("full in_rdy c%0d", cy), 64'(obs_in_rdy), 64'd0);
        end
        chk("accepted rows", 64'(acc), 64'd8);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
            if (j == 3) chk("in_rdy at 4th out", 64'(obs_in_rdy), 64'd0);
            if (j == 4) chk("in_rdy after drain", 64'(obs_in_rdy), 64'd1);
        end

        // Three matrices back-to-back at full rate
        drops = 0;
        hi = 0;
        for (int cy = 1; cy <= 16; cy++) begin
            cyc(1'b0, 1'(cy <= 12), {$urandom, $urandom}, 1'($urandom), 1'b1);
            if (cy <= 12 && !obs_in_rdy) drops++;
            if (cy >= 5 && obs_out_val) hi++;
        end
        chk("b2b in_rdy drops", 64'(drops), 64'd0);
        chk("b2b out_val cycles", 64'(hi), 64'd12);

        // Reset in the middle of a matrix
        cyc(1'b0, 1'b1, ref_in[0], 1'b0, 1'b1);
        cyc(1'b0, 1'b1, ref_in[1], 1'b0, 1'b1);
        cyc(1'b1, 1'b1, ref_in[2], 1'b0, 1'b1);
        chk("midrst in_rdy", 64'(obs_in_rdy), 64'd0);
        chk("midrst out_val", 64'(obs_out_val), 64'd0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("post rst in_rdy", 64'(obs_in_rdy), 64'd1);
        for (int r = 0; r < int'(N); r++) cyc(1'b0, 1'b1, ref_in[r], 1'b1, 1'b1);
        for (int k = 0; k < int'(N); k++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
            chk($sformatf("post rst row%0d", k), obs_out_row, vecs[0].exp[k]);
        end
        cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("post rst no stale", 64'(obs_out_val), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 9) < 7),
                {$urandom, $urandom}, 1'($urandom), 1'($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
